// File: rtl/sigdelay_multi.sv
// Multi-channel sample delay / feedback echo line.
// One time-multiplexed RAM holds CH circular banks that are processed serially each frame.
module sigdelay_multi #(
  parameter int A_WIDTH  = 9,
  parameter int D_WIDTH  = 8,
  parameter int CH       = 2,
  parameter int FB_SHIFT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic [CH*D_WIDTH-1:0]   din,
  input  logic [CH*A_WIDTH-1:0]   delay,
  input  logic [CH-1:0]           mode,
  output logic [CH*D_WIDTH-1:0]   dout,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int DEPTH = 1 << A_WIDTH;
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(CH - 1);
  localparam logic signed [D_WIDTH-1:0] SAT_MAX = {1'b0, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [D_WIDTH-1:0] SAT_MIN = {1'b1, {(D_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          ch;
  logic [A_WIDTH-1:0]     wr_ptr, fill;
  logic [CH*D_WIDTH-1:0]  din_r, res_r;
  logic [CH*A_WIDTH-1:0]  delay_r;
  logic [CH-1:0]          mode_r;
  logic [D_WIDTH-1:0]     mem [CH][DEPTH];
  logic [D_WIDTH-1:0]     rd_data;

  logic signed [D_WIDTH-1:0] x, tap, tap_sh, y_sat, y_store, y_out;
  logic signed [D_WIDTH:0]   sum;
  logic [A_WIDTH-1:0]        d, rd_addr;
  logic                      m;

  assign busy = (state != IDLE);

  // Datapath for the channel currently being serviced.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    x       = din_r[int'(ch)*D_WIDTH +: D_WIDTH];
    d       = delay_r[int'(ch)*A_WIDTH +: A_WIDTH];
    m       = mode_r[ch];
    rd_addr = wr_ptr - d;
    // History older than the number of frames written since reset reads as silence.
    tap     = (d != '0 && d <= fill) ? rd_data : '0;
    tap_sh  = tap >>> FB_SHIFT;
    sum     = {x[D_WIDTH-1], x} + {tap_sh[D_WIDTH-1], tap_sh};
    y_sat   = sum[D_WIDTH-1:0];
    if (sum[D_WIDTH] != sum[D_WIDTH-1])
      y_sat = sum[D_WIDTH] ? SAT_MIN : SAT_MAX;
    y_store = x;
    y_out   = x;
    if (d != '0) begin
      if (m) begin
        y_store = y_sat;
        y_out   = y_sat;
      end else begin
        y_out   = tap;
      end
    end
  end

  // NOTE: the sample RAM is deliberately left out of reset so it maps onto block RAM;
  // the fill count, not the RAM contents, decides which history is valid.
  always_ff @(posedge clk) begin
    if (state == RD)
      rd_data <= mem[ch][rd_addr];
    if (state == WR && rst)
      mem[ch][wr_ptr] <= y_store;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_en) state_nx = RD;
      RD:      state_nx = WR;
      WR:      state_nx = (ch == LAST_CH) ? DONE : RD;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ch        <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= 1'b0;
      if (sample_en && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: if (sample_en) begin
          din_r   <= din;
          delay_r <= delay;
          mode_r  <= mode;
          ch      <= '0;
        end
        WR: begin
          res_r[int'(ch)*D_WIDTH +: D_WIDTH] <= y_out;
          if (ch != LAST_CH)
            ch <= ch + 1'b1;
        end
        DONE: begin
          dout      <= res_r;
          out_valid <= 1'b1;
          wr_ptr    <= wr_ptr + 1'b1;
          if (fill != '1)
            fill <= fill + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sigdelay_multi.sv
// Scoreboard bench for sigdelay_multi: stimulus pushes hand-computed frame results,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_sigdelay_multi;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NC = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sample_en = 1'b0;
  logic [NC*DW-1:0]  din = '0;
  logic [NC*AW-1:0]  delay = '0;
  logic [NC-1:0]     mode = '0;
  logic [NC*DW-1:0]  dout;
  logic              out_valid, busy, overrun;

  int errors = 0;
  int checks = 0;
  logic [NC*DW-1:0] exp_q [$];
  logic [NC*DW-1:0] exp_v;

  always #5 clk = ~clk;

  sigdelay_multi #(.A_WIDTH(AW), .D_WIDTH(DW), .CH(NC), .FB_SHIFT(1)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .din(din), .delay(delay),
    .mode(mode), .dout(dout), .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every out_valid must match the oldest outstanding expected frame.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got dout=0x%0h, expected no output (t=%0t)", dout, $time);
      end else begin
        exp_v = exp_q.pop_front();
        check("frame_dout {ch1,ch0}", 32'(dout), 32'(exp_v));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    sample_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One frame every 8 cycles; inputs are scrambled while busy to show they are not resampled.
  task automatic frame(input logic [7:0] x0, input logic [7:0] x1,
                       input logic [3:0] d0, input logic [3:0] d1,
                       input logic m0, input logic m1,
                       input logic [7:0] e0, input logic [7:0] e1);
    @(negedge clk);
    din = {x1, x0};
    delay = {d1, d0};
    mode = {m1, m0};
    sample_en = 1'b1;
    exp_q.push_back({e1, e0});
    @(negedge clk);
    sample_en = 1'b0;
    din = 16'($urandom);
    delay = 8'($urandom);
    mode = 2'($urandom);
    repeat (6) @(negedge clk);
  endtask

  logic [7:0] imp_exp [8] = '{8'd100, 8'd0, 8'd50, 8'd0, 8'd25, 8'd0, 8'd12, 8'd0};
  logic [7:0] ind_in1 [9] = '{8'd80, 8'd0, 8'd0, 8'd0, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0] ind_ex1 [9] = '{8'd80, 8'd0, 8'd0, 8'd0, 8'd48, 8'd0, 8'd0, 8'd0, 8'd24};

  initial begin
    // Reset and latency: ch0 = 5 bypass.
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    din = {8'd0, 8'd5};
    delay = '0;
    mode = '0;
    sample_en = 1'b1;
    exp_q.push_back({8'd0, 8'd5});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      sample_en = 1'b0;
      check($sformatf("latency_busy_c%0d", k), 32'(busy), (k <= 5) ? 32'd1 : 32'd0);
      check($sformatf("latency_out_valid_c%0d", k), 32'(out_valid), (k == 6) ? 32'd1 : 32'd0);
      if (k <= 5) begin
        check($sformatf("latency_dout_c%0d", k), 32'(dout), 32'd0);
        check($sformatf("latency_overrun_c%0d", k), 32'(overrun), 32'd0);
      end
    end
    @(negedge clk);

    // Plain delay d=3 on ch0.
    do_reset();
    for (int i = 1; i <= 8; i++)
      frame(8'(i), 8'd0, 4'd3, 4'd0, 1'b0, 1'b0, (i > 3) ? 8'(i - 3) : 8'd0, 8'd0);

    // Max delay d=15 on ch1 across the pointer wrap; ch0 bypass.
    do_reset();
    for (int n = 0; n < 40; n++)
      frame(8'(n), 8'(n), 4'd0, 4'd15, 1'b0, 1'b0, 8'(n), (n >= 15) ? 8'(n - 15) : 8'd0);

    // Echo impulse d=2 on ch0.
    do_reset();
    for (int i = 0; i < 8; i++)
      frame((i == 0) ? 8'd100 : 8'd0, 8'd0, 4'd2, 4'd0, 1'b1, 1'b0, imp_exp[i], 8'd0);

    // Echo saturation: +127 on ch0, -128 on ch1, both d=1.
    do_reset();
    for (int i = 0; i < 4; i++)
      frame(8'd127, 8'h80, 4'd1, 4'd1, 1'b1, 1'b1, 8'd127, 8'h80);

    // Independence: ch0 delay d=1, ch1 echo d=4.
    do_reset();
    for (int i = 0; i < 9; i++)
      frame(8'(10 * (i + 1)), ind_in1[i], 4'd1, 4'd4, 1'b0, 1'b1,
            8'(10 * i), ind_ex1[i]);

    // Overrun: second strobe two cycles after acceptance is ignored.
    do_reset();
    @(negedge clk);
    din = {8'd0, 8'd7};
    delay = '0;
    mode = '0;
    sample_en = 1'b1;
    exp_q.push_back({8'd0, 8'd7});
    @(negedge clk);
    sample_en = 1'b0;
    @(negedge clk);
    din = {8'd0, 8'd55};
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    check("overrun_set", 32'(overrun), 32'd1);
    repeat (4) @(negedge clk);
    frame(8'd9, 8'd0, 4'd1, 4'd0, 1'b0, 1'b0, 8'd7, 8'd0);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset during RD(1): frame aborted, no output, history forgotten.
    @(negedge clk);
    din = {8'd0, 8'd77};
    delay = '0;
    mode = '0;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midreset_overrun", 32'(overrun), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    frame(8'd33, 8'd0, 4'd1, 4'd0, 1'b0, 1'b0, 8'd0, 8'd0);
    frame(8'd44, 8'd0, 4'd1, 4'd0, 1'b0, 1'b0, 8'd33, 8'd0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sigdelay_multi.md
Name: sigdelay_multi

Overview:
- Parametrised multi-channel successor to the single-channel mic delay line.
- Holds CH independent circular sample buffers in one time-multiplexed RAM, each 2^A_WIDTH deep.
- Each channel has a per-sample programmable delay and a mode select: plain delay or feedback echo.
- Sits between the Vbuddy mic sample path and the output/plot path; processes one multi-channel sample frame per sample_en strobe.

Parameters:
- A_WIDTH, 9: address width; buffer depth per channel = 2^A_WIDTH.
- D_WIDTH, 8: sample width; two's-complement signed.
- CH, 2: channel count, at least 1.
- FB_SHIFT, 1: echo feedback gain = 2^-FB_SHIFT, arithmetic right shift.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low: rst=0 at a rising edge resets.
- sample_en  in  1  frame strobe; accepted only in IDLE.
- din  in  CH*D_WIDTH  input samples; channel c occupies bits [c*D_WIDTH +: D_WIDTH].
- delay  in  CH*A_WIDTH  per-channel delay in samples, packed the same way.
- mode  in  CH  per-channel mode: 0 = delay, 1 = echo.
- dout  out  CH*D_WIDTH  output samples, registered.
- out_valid  out  1  one-cycle pulse when dout is updated.
- busy  out  1  high whenever the FSM is not in IDLE.
- overrun  out  1  sticky; set when sample_en arrives while busy.

Behaviour:
- Reset (rst=0 at an edge): FSM returns to IDLE; wr_ptr, fill count, dout, out_valid, busy and overrun all go to 0. RAM contents are not cleared.
- Reset mid-frame aborts the frame. No further RAM writes occur and no out_valid is produced.
- FSM states are IDLE, RD(c), WR(c) and DONE, with c running from 0 to CH-1.
- IDLE with sample_en=1: capture din, delay and mode into registers, set c=0, go to RD.
- RD(c): present read address rd = (wr_ptr - delay_c) mod 2^A_WIDTH for bank c. RAM read is synchronous with 1-cycle latency.
- WR(c): compute the channel result, write bank c at wr_ptr, then go to RD(c+1), or to DONE after c = CH-1.
- DONE: update dout, pulse out_valid=1 for exactly one cycle, increment wr_ptr (wraps at 2^A_WIDTH), saturate-increment fill, return to IDLE.
- Latency: sample_en accepted at edge 0; out_valid is high in the cycle after edge 2*CH+1. Maximum throughput is one frame per 2*CH+2 cycles.
- busy is high from the cycle after acceptance through the DONE cycle.
- Channel result, where d = delay_c, x = captured sample, m = RAM read data:
  - Valid-history rule: tap = m when 0 < d <= fill; tap = 0 when d > fill (unwritten history, including just after reset).
  - d = 0: bypass in both modes; store x, output x.
  - Delay mode: store x, output tap.
  - Echo mode: y = sat(x + (tap >>> FB_SHIFT)); store y, output y.
- sat() clamps the sum to [-2^(D_WIDTH-1), 2^(D_WIDTH-1)-1]; the sum is computed at D_WIDTH+1 bits.
- fill saturates at 2^A_WIDTH-1. The maximum delay of 2^A_WIDTH-1 is therefore fully supported after the buffer has filled.
- sample_en while busy: the frame is ignored (no capture) and overrun is set, staying set until reset.
- Changing delay, mode or din while busy has no effect on the current frame.
- Channels are fully independent; one channel's result never uses another bank.

Test Plan:
Test configuration is CH=2, A_WIDTH=4, D_WIDTH=8, FB_SHIFT=1, sample_en every 8 cycles unless stated.
- Reset/latency: hold rst=0 for 2 cycles, then release. Send ch0 = 5 with d = 0. Require out_valid exactly 6 cycles after acceptance, dout ch0 = 5, busy high for 5 cycles, dout and overrun 0 before that point.
- Plain delay: ch0 ramp 1, 2, 3, ... with d = 3, delay mode. Require outputs 0, 0, 0, 1, 2, 3 … (zeros until fill >= 3).
- Wrap/max delay: ch1 ramp with d = 15, running 40 frames. Require frame n (n >= 15) to output n-15 across the wr_ptr wrap at 16.
- Echo + saturation: ch0 impulse 100 then zeros, d = 2, echo mode. Require outputs 100, 0, 50, 0, 25, 0, 12 … Separately, a constant input of 127 with d = 1 must saturate at 127 and never wrap negative. Negative check: constant -128 must hold at -128.
- Channel independence: ch0 delay mode d = 1 and ch1 echo mode d = 4, driven simultaneously. Each channel's output must match its single-channel reference model.
- Overrun/reset mid-frame: assert sample_en 2 cycles after an accepted one. Require overrun = 1, no extra out_valid, and wr_ptr advanced by 1. Then assert rst=0 during RD(1): require no out_valid, overrun cleared, and the next frame to behave as just-after-reset (zero taps).
